// File: rtl/morra_pkg.sv
// morra_pkg: shared types for the MorraCinese scoreboard.
//   esito_t : manche / partita result encoding as driven by the FSMD
//   stato_t : scoreboard state
//   MAN_W   : width of the per-partita manche tallies
package morra_pkg;

  typedef enum logic [1:0] {
    NESSUNO  = 2'b00,
    PRIMO    = 2'b01,
    SECONDO  = 2'b10,
    PAREGGIO = 2'b11
  } esito_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    IN_GARA = 2'b01,
    FINE    = 2'b10
  } stato_t;

  localparam int MAN_W = 5;

  // Saturating increment for manche tallies (stick at all-ones).
  function automatic logic [MAN_W-1:0] man_inc(input logic [MAN_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

endpackage

// File: rtl/morra_hist_fifo.sv
// morra_hist_fifo: circular buffer of final partita results, drop-oldest on full.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   clr           synchronous flush
//   push, din     append a result
//   pop           remove head (ignored when empty)
//   valid, dout   head present / head value (00 when empty)
//   count         number of stored entries
module morra_hist_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [1:0]       din,
  input  logic             pop,
  output logic             valid,
  output logic [1:0]       dout,
  output logic [PTR_W:0]   count
);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd;
  logic [PTR_W:0]   cnt;
  logic [PTR_W-1:0] wr;
  logic             full, do_pop, drop;

  assign full   = (cnt == (PTR_W+1)'(DEPTH));
  // DEPTH is a power of two, so pointer wrap is free; on full this lands on rd,
  // overwriting the entry that is being dropped.
  assign wr     = rd + cnt[PTR_W-1:0];
  assign do_pop = pop && (cnt != '0);
  assign drop   = push && full && !do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd  <= '0;
      cnt <= '0;
    end else if (clr) begin
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_pop || drop)                 rd  <= rd + 1'b1;
      if (push && !do_pop && !full)       cnt <= cnt + 1'b1;
      else if (!push && do_pop)           cnt <= cnt - 1'b1;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr] <= din;
  end

  assign valid = (cnt != '0);
  assign dout  = valid ? mem[rd] : 2'b00;
  assign count = cnt;

endmodule

// File: rtl/morra_tabellone.sv
// morra_tabellone: scoreboard downstream of the MorraCinese FSMD.
// Samples Inizia/Manche/Partita each edge; keeps per-partita manche tallies,
// cumulative partita totals (saturating), aborted partite and last result.
// Optional history FIFO of final results when MORRA_HISTORY_EN is defined;
// otherwise hist_* outputs are tied to 0 and hist_pop is ignored.
// Ports:
//   clk, rst_n, clr            clock, async active-low reset, sync clear
//   Inizia, Manche, Partita    FSMD signals
//   stato                      00 IDLE, 01 IN_GARA, 10 FINE
//   man_primo/secondo/pari     manche tallies of current partita
//   vinte_primo/secondo, pareggi, interrotte   cumulative counters
//   ultimo_esito, fine_pulse   last final result, 1-cycle end pulse
//   hist_pop/valid/data/count  history readout
module morra_tabellone
  import morra_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          Inizia,
  input  logic [1:0]                    Manche,
  input  logic [1:0]                    Partita,
  output logic [1:0]                    stato,
  output logic [MAN_W-1:0]              man_primo,
  output logic [MAN_W-1:0]              man_secondo,
  output logic [MAN_W-1:0]              man_pari,
  output logic [CNT_W-1:0]              vinte_primo,
  output logic [CNT_W-1:0]              vinte_secondo,
  output logic [CNT_W-1:0]              pareggi,
  output logic [CNT_W-1:0]              interrotte,
  output logic [1:0]                    ultimo_esito,
  output logic                          fine_pulse,
  input  logic                          hist_pop,
  output logic                          hist_valid,
  output logic [1:0]                    hist_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);

  stato_t st;
  logic   fine_evt;

  // A partita ends only in IN_GARA, without a concurrent restart or clear.
  assign fine_evt = !clr && !Inizia && (st == IN_GARA) && (Partita != NESSUNO);
  assign stato    = st;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st            <= IDLE;
      man_primo     <= '0;
      man_secondo   <= '0;
      man_pari      <= '0;
      vinte_primo   <= '0;
      vinte_secondo <= '0;
      pareggi       <= '0;
      interrotte    <= '0;
      ultimo_esito  <= 2'b00;
      fine_pulse    <= 1'b0;
    end else if (clr) begin
      st            <= IDLE;
      man_primo     <= '0;
      man_secondo   <= '0;
      man_pari      <= '0;
      vinte_primo   <= '0;
      vinte_secondo <= '0;
      pareggi       <= '0;
      interrotte    <= '0;
      ultimo_esito  <= 2'b00;
      fine_pulse    <= 1'b0;
    end else begin
      fine_pulse <= fine_evt;
      if (Inizia) begin
        // FSMD is configuring this cycle: its Manche/Partita are meaningless.
        if (st == IN_GARA) interrotte <= cnt_inc(interrotte);
        man_primo   <= '0;
        man_secondo <= '0;
        man_pari    <= '0;
        st          <= IN_GARA;
      end else if (st == IN_GARA) begin
        // The final manche is reported together with Partita, so count it first.
        case (esito_t'(Manche))
          PRIMO:    man_primo   <= man_inc(man_primo);
          SECONDO:  man_secondo <= man_inc(man_secondo);
          PAREGGIO: man_pari    <= man_inc(man_pari);
          default:  ;
        endcase
        if (Partita != NESSUNO) begin
          case (esito_t'(Partita))
            PRIMO:   vinte_primo   <= cnt_inc(vinte_primo);
            SECONDO: vinte_secondo <= cnt_inc(vinte_secondo);
            default: pareggi       <= cnt_inc(pareggi);
          endcase
          ultimo_esito <= Partita;
          st           <= FINE;
        end
      end
    end
  end

`ifdef MORRA_HISTORY_EN
  morra_hist_fifo #(.DEPTH(HIST_DEPTH)) u_hist (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (fine_evt),
    .din   (Partita),
    .pop   (hist_pop && !clr),
    .valid (hist_valid),
    .dout  (hist_data),
    .count (hist_count)
  );
`else
  assign hist_valid = 1'b0;
  assign hist_data  = 2'b00;
  assign hist_count = '0;
`endif

endmodule

// File: tb/tb_morra_tabellone.sv
// Randomized + directed bench for morra_tabellone against a behavioural
// scoreboard model (integers, saturation by comparison, queue for history).
module tb_morra_tabellone;

  localparam int CNT_W = 8;
  localparam int HD    = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int MMAX  = 31;

  logic                 clk, rst_n, clr, Inizia, hist_pop;
  logic [1:0]           Manche, Partita, stato, ultimo_esito, hist_data;
  logic [4:0]           man_primo, man_secondo, man_pari;
  logic [CNT_W-1:0]     vinte_primo, vinte_secondo, pareggi, interrotte;
  logic                 fine_pulse, hist_valid;
  logic [$clog2(HD):0]  hist_count;

  morra_tabellone #(.CNT_W(CNT_W), .HIST_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .Inizia(Inizia), .Manche(Manche),
    .Partita(Partita), .stato(stato), .man_primo(man_primo),
    .man_secondo(man_secondo), .man_pari(man_pari), .vinte_primo(vinte_primo),
    .vinte_secondo(vinte_secondo), .pareggi(pareggi), .interrotte(interrotte),
    .ultimo_esito(ultimo_esito), .fine_pulse(fine_pulse), .hist_pop(hist_pop),
    .hist_valid(hist_valid), .hist_data(hist_data), .hist_count(hist_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // reference model: 0 idle, 1 in gara, 2 fine
  int m_st, m_mp, m_ms, m_mx, m_vp, m_vs, m_pa, m_in, m_ult, m_fp;
  int hq[$];

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int x, input int mx);
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic m_reset();
    m_st = 0; m_mp = 0; m_ms = 0; m_mx = 0; m_vp = 0; m_vs = 0;
    m_pa = 0; m_in = 0; m_ult = 0; m_fp = 0;
    hq.delete();
  endtask

  task automatic m_edge(input int c, input int i, input int m, input int p, input int pp);
    if (c != 0) begin
      m_reset();
      return;
    end
    m_fp = 0;
    if (pp != 0 && hq.size() > 0) void'(hq.pop_front());
    if (i != 0) begin
      if (m_st == 1) m_in = sat(m_in, CMAX);
      m_mp = 0; m_ms = 0; m_mx = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (m == 1) m_mp = sat(m_mp, MMAX);
      if (m == 2) m_ms = sat(m_ms, MMAX);
      if (m == 3) m_mx = sat(m_mx, MMAX);
      if (p != 0) begin
        if (p == 1) m_vp = sat(m_vp, CMAX);
        if (p == 2) m_vs = sat(m_vs, CMAX);
        if (p == 3) m_pa = sat(m_pa, CMAX);
        m_ult = p; m_fp = 1; m_st = 2;
        if (hq.size() == HD) void'(hq.pop_front());
        hq.push_back(p);
      end
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".stato"}, stato, m_st);
    chk({t, ".man_primo"}, man_primo, m_mp);
    chk({t, ".man_secondo"}, man_secondo, m_ms);
    chk({t, ".man_pari"}, man_pari, m_mx);
    chk({t, ".vinte_primo"}, vinte_primo, m_vp);
    chk({t, ".vinte_secondo"}, vinte_secondo, m_vs);
    chk({t, ".pareggi"}, pareggi, m_pa);
    chk({t, ".interrotte"}, interrotte, m_in);
    chk({t, ".ultimo_esito"}, ultimo_esito, m_ult);
    chk({t, ".fine_pulse"}, fine_pulse, m_fp);
`ifdef MORRA_HISTORY_EN
    chk({t, ".hist_valid"}, hist_valid, (hq.size() > 0) ? 1 : 0);
    chk({t, ".hist_data"}, hist_data, (hq.size() > 0) ? hq[0] : 0);
    chk({t, ".hist_count"}, hist_count, hq.size());
`else
    chk({t, ".hist_valid"}, hist_valid, 0);
    chk({t, ".hist_count"}, hist_count, 0);
`endif
  endtask

  // Apply inputs, clock once, advance the model, sample 1 time unit later.
  task automatic step(input string t, input int c, input int i, input int m,
                      input int p, input int pp);
    clr = (c != 0); Inizia = (i != 0); Manche = 2'(m); Partita = 2'(p);
    hist_pop = (pp != 0);
    @(posedge clk);
    m_edge(c, i, m, p, pp);
    #1 check_all(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; Inizia = 1'b0; Manche = 2'b00; Partita = 2'b00;
    hist_pop = 1'b0;
    m_reset();
    #3 check_all("reset");
    #4 rst_n = 1'b1;

    // 1: async reset mid-partita
    step("t1a", 0, 1, 0, 0, 0);
    step("t1b", 0, 0, 1, 0, 0);
    step("t1c", 0, 0, 1, 0, 0);
    chk("t1.man_primo_pre", man_primo, 2);
    #1 rst_n = 1'b0;
    m_reset();
    #1 check_all("t1_async");
    chk("t1.stato_async", stato, 0);
    #1 rst_n = 1'b1;

    // 2: a won partita
    step("t2a", 0, 1, 0, 0, 0);
    step("t2b", 0, 0, 2, 0, 0);
    step("t2c", 0, 0, 1, 0, 0);
    step("t2d", 0, 0, 1, 1, 0);
    chk("t2.man_primo", man_primo, 2);
    chk("t2.man_secondo", man_secondo, 1);
    chk("t2.vinte_primo", vinte_primo, 1);
    chk("t2.ultimo_esito", ultimo_esito, 1);
    chk("t2.fine_pulse_hi", fine_pulse, 1);
    chk("t2.stato", stato, 2);
    step("t2e", 0, 0, 0, 0, 0);
    chk("t2.fine_pulse_lo", fine_pulse, 0);

    // 3: restart while in gara
    step("t3a", 0, 1, 0, 0, 0);
    step("t3b", 0, 0, 2, 0, 0);
    step("t3c", 0, 1, 1, 0, 0);
    chk("t3.interrotte", interrotte, 1);
    chk("t3.man_primo", man_primo, 0);
    chk("t3.man_secondo", man_secondo, 0);
    chk("t3.stato", stato, 1);

    // 4: FINE ignores Manche/Partita, then clr
    step("t4a", 0, 0, 0, 2, 0);
    step("t4b", 0, 0, 1, 2, 0);
    chk("t4.vinte_secondo", vinte_secondo, 1);
    chk("t4.man_primo", man_primo, 0);
    step("t4c", 1, 0, 0, 0, 0);
    chk("t4.clr_vinte_primo", vinte_primo, 0);
    chk("t4.clr_stato", stato, 0);

    // 6: history fill, overflow, push+pop
    begin
      int res[5] = '{1, 2, 3, 1, 2};
      foreach (res[k]) begin
        step("t6i", 0, 1, 0, 0, 0);
        step("t6p", 0, 0, 0, res[k], 0);
      end
`ifdef MORRA_HISTORY_EN
      chk("t6.hist_count", hist_count, 4);
      chk("t6.hist_data", hist_data, 2);
      step("t6i", 0, 1, 0, 0, 0);
      step("t6pp", 0, 0, 0, 3, 1);
      chk("t6.hist_count_pp", hist_count, 4);
      chk("t6.hist_data_pp", hist_data, 3);
`else
      chk("t6.hist_valid_off", hist_valid, 0);
`endif
      step("t6x", 0, 0, 0, 0, 1);
      step("t6x", 0, 0, 0, 0, 1);
    end

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int c, i, m, p, pp;
      c  = ($urandom_range(0, 59) == 0) ? 1 : 0;
      i  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      m  = $urandom_range(0, 3);
      p  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      pp = ($urandom_range(0, 2) == 0) ? 1 : 0;
      step("rnd", c, i, m, p, pp);
    end

    // 5: saturation
    step("t5c", 1, 0, 0, 0, 0);
    for (int n = 0; n < 257; n++) begin
      step("t5i", 0, 1, 0, 0, 0);
      step("t5w", 0, 0, 1, 1, 0);
    end
    chk("t5.vinte_primo_sat", vinte_primo, 255);
    step("t5j", 0, 1, 0, 0, 0);
    for (int n = 0; n < 35; n++) step("t5d", 0, 0, 3, 0, 0);
    chk("t5.man_pari_sat", man_pari, 31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
